piece_drop_ctrl: RTL

PIECE_DROP_CTRL -- requirements
Module: piece_drop_ctrl

---
 rtl/piece_pkg.sv | 27 ++
 rtl/piece_fit_check.sv | 38 +++
 rtl/piece_drop_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/piece_pkg.sv
// Shared definitions for the falling-piece controller: FSM states, default
// board/timing constants and small coordinate helpers.
package piece_pkg;

    localparam int DEF_BOARD_W    = 8;
    localparam int DEF_BOARD_H    = 8;
    localparam int DEF_GRAV_TICKS = 4;
    localparam int DEF_LOCK_TICKS = 2;
    localparam int NUM_CELLS      = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FALL      = 2'd1,
        LOCK_WAIT = 2'd2,
        LANDED    = 2'd3
    } drop_state_e;

    function automatic bit coordInRange(input int coord, input int limit);
        return (coord >= 0) && (coord < limit);
    endfunction

    // Counters must hold the larger of the two tick limits without wrapping.
    function automatic int cntWidth(input int gravTicks, input int lockTicks);
        return $clog2(((gravTicks > lockTicks) ? gravTicks : lockTicks) + 1);
    endfunction

endpackage

// File: rtl/piece_fit_check.sv
// Combinational test of whether the four piece cells, shifted by (DX,DY),
// all stay on the board and land on empty squares.
module piece_fit_check
    import piece_pkg::*;
#(
    parameter int BOARD_W = DEF_BOARD_W,
    parameter int BOARD_H = DEF_BOARD_H,
    parameter int XW      = $clog2(BOARD_W),
    parameter int YW      = $clog2(BOARD_H),
    parameter int DX      = 0,
    parameter int DY      = 0
) (
    input  logic [NUM_CELLS-1:0][XW-1:0]     cellX,
    input  logic [NUM_CELLS-1:0][YW-1:0]     cellY,
    input  logic [BOARD_H-1:0][BOARD_W-1:0]  board,
    output logic                             fit
);

    int nx;
    int ny;

    // The board lookup is only reached once the shifted cell is known to be in range.
    always_comb begin
        fit = 1'b1;
        nx  = 0;
        ny  = 0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            nx = int'(cellX[i]) + DX;
            ny = int'(cellY[i]) + DY;
            if (!coordInRange(nx, BOARD_W) || !coordInRange(ny, BOARD_H)) begin
                fit = 1'b0;
            end else if (board[ny[YW-1:0]][nx[XW-1:0]]) begin
                fit = 1'b0;
            end
        end
    end

endmodule

// File: rtl/piece_drop_ctrl.sv
// Falling-piece controller: spawns a four-cell piece, applies sideways moves
// and gravity against the board, and locks the piece after a grounded delay.
module piece_drop_ctrl
    import piece_pkg::*;
#(
    parameter int BOARD_W    = DEF_BOARD_W,
    parameter int BOARD_H    = DEF_BOARD_H,
    parameter int GRAV_TICKS = DEF_GRAV_TICKS,
    parameter int LOCK_TICKS = DEF_LOCK_TICKS,
    parameter int XW         = $clog2(BOARD_W),
    parameter int YW         = $clog2(BOARD_H)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             spawn,
    input  logic [NUM_CELLS-1:0][XW-1:0]     spawnX,
    input  logic [NUM_CELLS-1:0][YW-1:0]     spawnY,
    input  logic                             move_left,
    input  logic                             move_right,
    input  logic                             soft_drop,
    input  logic [BOARD_H-1:0][BOARD_W-1:0]  board,
    output logic [NUM_CELLS-1:0][XW-1:0]     cellX,
    output logic [NUM_CELLS-1:0][YW-1:0]     cellY,
    output logic                             active,
    output logic                             land,
    output logic                             top_out
);

    localparam int            CW        = cntWidth(GRAV_TICKS, LOCK_TICKS);
    localparam logic [CW-1:0] GRAV_LAST = CW'(GRAV_TICKS - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TICKS - 1);

    drop_state_e                   state_q, state_d;
    logic [NUM_CELLS-1:0][XW-1:0]  cellX_q, cellX_d;
    logic [NUM_CELLS-1:0][YW-1:0]  cellY_q, cellY_d;
    logic [CW-1:0]                 gravCnt_q, gravCnt_d;
    logic [CW-1:0]                 lockCnt_q, lockCnt_d;
    logic                          topOut_q, topOut_d;

    logic canDown, canLeft, canRight, canDownLeft, canDownRight, canSpawn;
    logic wantLeft, wantRight, moveOk, fitBelowNext, gravDue;
    logic [NUM_CELLS-1:0][XW-1:0]  shiftedX;
    logic [NUM_CELLS-1:0][YW-1:0]  downY;

    piece_fit_check #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .XW(XW), .YW(YW), .DX(0), .DY(1))
        uFitDown (.cellX(cellX_q), .cellY(cellY_q), .board(board), .fit(canDown));
    piece_fit_check #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .XW(XW), .YW(YW), .DX(-1), .DY(0))
        uFitLeft (.cellX(cellX_q), .cellY(cellY_q), .board(board), .fit(canLeft));
    piece_fit_check #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .XW(XW), .YW(YW), .DX(1), .DY(0))
        uFitRight (.cellX(cellX_q), .cellY(cellY_q), .board(board), .fit(canRight));
    piece_fit_check #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .XW(XW), .YW(YW), .DX(-1), .DY(1))
        uFitDownLeft (.cellX(cellX_q), .cellY(cellY_q), .board(board), .fit(canDownLeft));
    piece_fit_check #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .XW(XW), .YW(YW), .DX(1), .DY(1))
        uFitDownRight (.cellX(cellX_q), .cellY(cellY_q), .board(board), .fit(canDownRight));
    piece_fit_check #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .XW(XW), .YW(YW), .DX(0), .DY(0))
        uFitSpawn (.cellX(spawnX), .cellY(spawnY), .board(board), .fit(canSpawn));

    // Diagonal fits tell whether a sideways move in LOCK_WAIT un-grounds the piece.
    always_comb begin
        wantLeft  = move_left && !move_right;
        wantRight = move_right && !move_left;
        moveOk    = (wantLeft && canLeft) || (wantRight && canRight);
        gravDue   = (gravCnt_q == GRAV_LAST) || soft_drop;
        if (moveOk) begin
            fitBelowNext = wantLeft ? canDownLeft : canDownRight;
        end else begin
            fitBelowNext = canDown;
        end
        for (int i = 0; i < NUM_CELLS; i++) begin
            shiftedX[i] = wantLeft ? (cellX_q[i] - XW'(1)) : (cellX_q[i] + XW'(1));
            downY[i]    = cellY_q[i] + YW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        cellX_d   = cellX_q;
        cellY_d   = cellY_q;
        gravCnt_d = gravCnt_q;
        lockCnt_d = lockCnt_q;
        topOut_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (spawn) begin
                    if (canSpawn) begin
                        state_d   = FALL;
                        cellX_d   = spawnX;
                        cellY_d   = spawnY;
                        gravCnt_d = '0;
                        lockCnt_d = '0;
                    end else begin
                        topOut_d = 1'b1;
                    end
                end
            end
            FALL: begin
                // A move takes this cycle's slot; a due gravity step waits at the saturated count.
                if (moveOk) begin
                    cellX_d = shiftedX;
                    if (gravCnt_q != GRAV_LAST) begin
                        gravCnt_d = gravCnt_q + CW'(1);
                    end
                end else if (gravDue) begin
                    if (canDown) begin
                        cellY_d   = downY;
                        gravCnt_d = '0;
                    end else begin
                        state_d   = LOCK_WAIT;
                        lockCnt_d = '0;
                    end
                end else begin
                    gravCnt_d = gravCnt_q + CW'(1);
                end
            end
            LOCK_WAIT: begin
                if (moveOk) begin
                    cellX_d = shiftedX;
                end
                if (fitBelowNext) begin
                    state_d   = FALL;
                    gravCnt_d = '0;
                end else if (lockCnt_q == LOCK_LAST) begin
                    state_d = LANDED;
                end else begin
                    lockCnt_d = lockCnt_q + CW'(1);
                end
            end
            LANDED: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cellX_q   <= '0;
            cellY_q   <= '0;
            gravCnt_q <= '0;
            lockCnt_q <= '0;
            topOut_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cellX_q   <= cellX_d;
            cellY_q   <= cellY_d;
            gravCnt_q <= gravCnt_d;
            lockCnt_q <= lockCnt_d;
            topOut_q  <= topOut_d;
        end
    end

    assign cellX   = cellX_q;
    assign cellY   = cellY_q;
    assign active  = (state_q == FALL) || (state_q == LOCK_WAIT);
    assign land    = (state_q == LANDED);
    assign top_out = topOut_q;

endmodule
